// File: rtl/pic_inta_sequencer_pkg.sv
// pic_pkg: shared types and constants for the 8259A-style PIC control path.
package pic_pkg;
  localparam int NUM_IR = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
  typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_e;
endpackage

// File: rtl/pic_inta_sequencer_if.sv
// pic_inta_sequencer_if: CPU INTA / resolver / OCW2 signals of the INTA sequencer.
interface pic_inta_sequencer_if;
  logic       inta_n;
  logic       int_req;
  logic [2:0] int_vec;
  logic [4:0] vec_base;
  logic       aeoi;
  logic [2:0] lowest_prio;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic       freeze;
  logic [7:0] isr;
  logic [7:0] data_out;
  logic       data_oe;
  logic       aeoi_done;
  logic       seq_err;
  modport master (
    output inta_n, int_req, int_vec, vec_base, aeoi, lowest_prio, eoi_valid, eoi_specific, eoi_level,
    input  int_out, freeze, isr, data_out, data_oe, aeoi_done, seq_err
  );
  modport slave (
    input  inta_n, int_req, int_vec, vec_base, aeoi, lowest_prio, eoi_valid, eoi_specific, eoi_level,
    output int_out, freeze, isr, data_out, data_oe, aeoi_done, seq_err
  );
endinterface

// File: rtl/pic_inta_sequencer_priority_find.sv
// pic_priority_find: highest-priority set bit; level lowest_prio+1 ranks first, then ascending with wrap.
module pic_priority_find
  import pic_pkg::*;
(
  input  logic [NUM_IR-1:0] vec_i,
  input  logic [2:0]        lowest_prio_i,
  output logic [2:0]        idx_o,
  output logic              valid_o
);
  logic [2:0] lvl;
  always_comb begin
    idx_o = '0;
    valid_o = 1'b0;
    lvl = '0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      lvl = lowest_prio_i + 3'(k) + 3'd1;
      if (vec_i[lvl]) begin
        idx_o = lvl;
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: two-pulse INTA handshake, ISR ownership, vector drive and EOI handling.
module pic_inta_sequencer
  import pic_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst_n,
  pic_inta_sequencer_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  logic sync1_q, sync2_q, dly_q;
  logic [2:0] vec_q, vec_d;
  logic spur_q, spur_d;
  logic [NUM_IR-1:0] isr_q, isr_d, isr_set, isr_clr, eoi_clr;
  logic int_out_q, int_out_d, freeze_q, freeze_d, oe_q, oe_d;
  logic aeoi_done_q, aeoi_done_d, err_q, err_d;
  logic [7:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fall, rise, pf_valid;
  logic [2:0] pf_idx;
  assign fall = dly_q & ~sync2_q;
  assign rise = ~dly_q & sync2_q;
  pic_priority_find u_find (
    .vec_i(isr_q), .lowest_prio_i(bus.lowest_prio), .idx_o(pf_idx), .valid_o(pf_valid)
  );
  // EOI search runs on the pre-update ISR; a same-cycle set of the same bit wins.
  assign eoi_clr = !bus.eoi_valid ? '0 :
                   bus.eoi_specific ? NUM_IR'(1) << bus.eoi_level :
                   pf_valid ? NUM_IR'(1) << pf_idx : '0;
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    spur_d = spur_q;
    int_out_d = int_out_q;
    freeze_d = freeze_q;
    oe_d = oe_q;
    data_d = data_q;
    err_d = err_q;
    cnt_d = cnt_q;
    aeoi_done_d = 1'b0;
    isr_set = '0;
    isr_clr = '0;
    case (state_q)
      IDLE: begin
        int_out_d = bus.int_req;
        if (fall) begin
          state_d = ACK1;
          vec_d = bus.int_req ? bus.int_vec : SPURIOUS_LEVEL;
          spur_d = ~bus.int_req;
          isr_set = bus.int_req ? NUM_IR'(1) << bus.int_vec : '0;
          int_out_d = 1'b0;
          freeze_d = 1'b1;
        end
      end
      ACK1: if (rise) begin
        state_d = GAP;
        cnt_d = '0;
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (fall) begin
          state_d = ACK2;
          data_d = {bus.vec_base, vec_q};
          oe_d = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          freeze_d = 1'b0;
          err_d = 1'b1;
        end
      end
      ACK2: if (rise) begin
        state_d = IDLE;
        oe_d = 1'b0;
        freeze_d = 1'b0;
        isr_clr = (bus.aeoi && !spur_q) ? NUM_IR'(1) << vec_q : '0;
        aeoi_done_d = bus.aeoi && !spur_q;
      end
      default: state_d = IDLE;
    endcase
    isr_d = (isr_q & ~(isr_clr | eoi_clr)) | isr_set;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {sync1_q, sync2_q, dly_q} <= 3'b111;
      state_q <= IDLE;
      vec_q <= '0;
      spur_q <= 1'b0;
      isr_q <= '0;
      int_out_q <= 1'b0;
      freeze_q <= 1'b0;
      oe_q <= 1'b0;
      data_q <= '0;
      aeoi_done_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      {sync1_q, sync2_q, dly_q} <= {bus.inta_n, sync1_q, sync2_q};
      state_q <= state_d;
      vec_q <= vec_d;
      spur_q <= spur_d;
      isr_q <= isr_d;
      int_out_q <= int_out_d;
      freeze_q <= freeze_d;
      oe_q <= oe_d;
      data_q <= data_d;
      aeoi_done_q <= aeoi_done_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.int_out = int_out_q;
  assign bus.freeze = freeze_q;
  assign bus.isr = isr_q;
  assign bus.data_out = data_q;
  assign bus.data_oe = oe_q;
  assign bus.aeoi_done = aeoi_done_q;
  assign bus.seq_err = err_q;
endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer: directed INTA/EOI scenarios; vector bytes and AEOI results are scoreboarded.
module tb_pic_inta_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_data_q[$];
  logic [7:0] exp_isr_q[$];
  logic oe_prev = 1'b0;
  logic ad_prev = 1'b0;
  pic_inta_sequencer_if bus();
  pic_inta_sequencer #(.TIMEOUT_CYCLES(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask
  task automatic fail(input string name, input logic [7:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %02h, no value expected", name, act);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic inta(input logic lvl);
    bus.inta_n = lvl;
    cyc(6);
  endtask
  task automatic eoi(input logic spec, input logic [2:0] lvl);
    bus.eoi_valid = 1'b1;
    bus.eoi_specific = spec;
    bus.eoi_level = lvl;
    cyc(1);
    bus.eoi_valid = 1'b0;
    cyc(1);
  endtask
  task automatic full_seq(input logic [2:0] v);
    bus.int_req = 1'b1;
    bus.int_vec = v;
    cyc(2);
    exp_data_q.push_back({bus.vec_base, v});
    inta(0); inta(1); inta(0); inta(1);
  endtask
  // Scoreboard monitor: vector byte on each data_oe rise, ISR on each aeoi_done pulse.
  always @(negedge clk) begin
    if (bus.data_oe && !oe_prev) begin
      if (exp_data_q.size() == 0) fail("unexpected data_oe", bus.data_out);
      else check("data_out", bus.data_out, exp_data_q.pop_front());
    end
    if (bus.aeoi_done) begin
      if (ad_prev) fail("aeoi_done wider than one cycle", bus.isr);
      else if (exp_isr_q.size() == 0) fail("unexpected aeoi_done", bus.isr);
      else check("isr at aeoi_done", bus.isr, exp_isr_q.pop_front());
    end
    oe_prev = bus.data_oe;
    ad_prev = bus.aeoi_done;
  end
  initial begin
    bus.inta_n = 1'b1;
    bus.int_req = 1'b0;
    bus.int_vec = 3'd0;
    bus.vec_base = 5'b01000;
    bus.aeoi = 1'b0;
    bus.lowest_prio = 3'd7;
    bus.eoi_valid = 1'b0;
    bus.eoi_specific = 1'b0;
    bus.eoi_level = 3'd0;
    cyc(2);
    check("reset isr", bus.isr, 8'h00);
    check("reset int_out", 8'(bus.int_out), 8'h0);
    check("reset freeze", 8'(bus.freeze), 8'h0);
    check("reset data_oe", 8'(bus.data_oe), 8'h0);
    check("reset data_out", bus.data_out, 8'h00);
    check("reset seq_err", 8'(bus.seq_err), 8'h0);
    rst_n = 1'b1;
    cyc(2);
    // normal fixed-priority sequence, IR3
    bus.int_req = 1'b1;
    bus.int_vec = 3'd3;
    cyc(3);
    check("int_out follows int_req", 8'(bus.int_out), 8'h1);
    exp_data_q.push_back(8'h43);
    inta(0);
    check("isr after pulse 1", bus.isr, 8'h08);
    check("int_out after pulse 1", 8'(bus.int_out), 8'h0);
    check("freeze after pulse 1", 8'(bus.freeze), 8'h1);
    inta(1);
    inta(0);
    check("data_oe in pulse 2", 8'(bus.data_oe), 8'h1);
    inta(1);
    check("data_oe after pulse 2", 8'(bus.data_oe), 8'h0);
    check("freeze after pulse 2", 8'(bus.freeze), 8'h0);
    check("isr kept without aeoi", bus.isr, 8'h08);
    check("data_out holds", bus.data_out, 8'h43);
    eoi(1'b1, 3'd3);
    check("specific eoi", bus.isr, 8'h00);
    // spurious: request gone before first INTA, AEOI enabled but must not fire
    bus.int_req = 1'b0;
    bus.aeoi = 1'b1;
    cyc(2);
    check("int_out low without req", 8'(bus.int_out), 8'h0);
    exp_data_q.push_back(8'h47);
    inta(0);
    check("spurious isr pulse 1", bus.isr, 8'h00);
    inta(1); inta(0); inta(1);
    check("spurious isr pulse 2", bus.isr, 8'h00);
    // automatic EOI, IR5
    bus.int_req = 1'b1;
    bus.int_vec = 3'd5;
    cyc(2);
    exp_data_q.push_back(8'h45);
    exp_isr_q.push_back(8'h00);
    inta(0);
    check("aeoi isr pulse 1", bus.isr, 8'h20);
    inta(1);
    check("aeoi isr between pulses", bus.isr, 8'h20);
    inta(0); inta(1);
    check("aeoi isr after", bus.isr, 8'h00);
    bus.aeoi = 1'b0;
    // rotating non-specific EOI
    full_seq(3'd0);
    full_seq(3'd4);
    full_seq(3'd7);
    check("isr built", bus.isr, 8'h91);
    bus.lowest_prio = 3'd3;
    eoi(1'b0, 3'd0);
    check("rot eoi 1", bus.isr, 8'h81);
    eoi(1'b0, 3'd0);
    check("rot eoi 2", bus.isr, 8'h01);
    bus.lowest_prio = 3'd7;
    eoi(1'b0, 3'd0);
    check("fixed eoi", bus.isr, 8'h00);
    eoi(1'b0, 3'd0);
    check("eoi on empty isr", bus.isr, 8'h00);
    // timeout: single INTA pulse, IR2
    bus.int_vec = 3'd2;
    cyc(2);
    inta(0); inta(1);
    cyc(4);
    check("freeze during gap", 8'(bus.freeze), 8'h1);
    check("no seq_err yet", 8'(bus.seq_err), 8'h0);
    cyc(70);
    check("freeze after timeout", 8'(bus.freeze), 8'h0);
    check("seq_err after timeout", 8'(bus.seq_err), 8'h1);
    check("isr kept after timeout", bus.isr, 8'h04);
    check("int_out back in idle", 8'(bus.int_out), 8'h1);
    full_seq(3'd6);
    check("isr after recovery", bus.isr, 8'h44);
    check("seq_err sticky", 8'(bus.seq_err), 8'h1);
    // asynchronous reset during ACK2
    bus.int_vec = 3'd1;
    exp_data_q.push_back(8'h41);
    inta(0); inta(1); inta(0);
    check("in ack2 data_oe", 8'(bus.data_oe), 8'h1);
    check("in ack2 isr", bus.isr, 8'h46);
    #2 rst_n = 1'b0;
    #1;
    check("async rst data_oe", 8'(bus.data_oe), 8'h0);
    check("async rst freeze", 8'(bus.freeze), 8'h0);
    check("async rst isr", bus.isr, 8'h00);
    check("async rst seq_err", 8'(bus.seq_err), 8'h0);
    bus.inta_n = 1'b1;
    bus.int_req = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    if (exp_data_q.size() != 0) fail("vector byte never presented", 8'(exp_data_q.size()));
    if (exp_isr_q.size() != 0) fail("aeoi_done never pulsed", 8'(exp_isr_q.size()));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
